// File: rtl/alsu_result_flag_fifo.sv
// Result/flag FIFO for the ALSU negative-sign path: qualifies the negative flag and derives
// a zero flag at write time, presents a show-ahead head entry, and keeps sticky status.
module alsu_result_flag_fifo #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic                       Wr_Valid,
    output logic                       Wr_Ready,
    input  logic [3:0]                 Sel,
    input  logic [DATA_W-1:0]          Result,
    input  logic                       Negative_Sign_Flag,
    output logic                       Rd_Valid,
    input  logic                       Rd_Ready,
    output logic [3:0]                 Rd_Sel,
    output logic [DATA_W-1:0]          Rd_Result,
    output logic                       Rd_Negative,
    output logic                       Rd_Zero,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overflow_Sticky,
    output logic [7:0]                 Neg_Count,
    input  logic                       Clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [3:0]        sel_mem  [DEPTH];
    logic [DATA_W-1:0] res_mem  [DEPTH];
    logic              neg_mem  [DEPTH];
    logic              zero_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    neg_cnt_q, neg_cnt_d;

    logic full, empty, wr_acc, rd_acc, wr_neg, wr_zero;

    // Extra pointer MSB separates full (MSB differs) from empty (identical).
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign wr_acc  = Wr_Valid && !full;
    assign rd_acc  = Rd_Ready && !empty;
    assign wr_neg  = Negative_Sign_Flag && ((Sel == 4'b0000) || (Sel == 4'b1100));
    assign wr_zero = (Result == '0);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        neg_cnt_d = neg_cnt_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        // A new overflow attempt takes priority over Clear.
        if (Wr_Valid && full) begin
            ovf_d = 1'b1;
        end else if (Clear) begin
            ovf_d = 1'b0;
        end
        if (Clear) begin
            neg_cnt_d = (wr_acc && wr_neg) ? 8'd1 : 8'd0;
        end else if (wr_acc && wr_neg && (neg_cnt_q != 8'hFF)) begin
            neg_cnt_d = neg_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            neg_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            neg_cnt_q <= neg_cnt_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sel_mem[i]  <= 4'd0;
                res_mem[i]  <= '0;
                neg_mem[i]  <= 1'b0;
                zero_mem[i] <= 1'b0;
            end
        end else if (wr_acc) begin
            sel_mem[wr_ptr_q[AW-1:0]]  <= Sel;
            res_mem[wr_ptr_q[AW-1:0]]  <= Result;
            neg_mem[wr_ptr_q[AW-1:0]]  <= wr_neg;
            zero_mem[wr_ptr_q[AW-1:0]] <= wr_zero;
        end
    end

    assign Wr_Ready        = !full;
    assign Rd_Valid        = !empty;
    assign Rd_Sel          = sel_mem[rd_ptr_q[AW-1:0]];
    assign Rd_Result       = res_mem[rd_ptr_q[AW-1:0]];
    assign Rd_Negative     = neg_mem[rd_ptr_q[AW-1:0]];
    assign Rd_Zero         = zero_mem[rd_ptr_q[AW-1:0]];
    assign Count           = wr_ptr_q - rd_ptr_q;
    assign Overflow_Sticky = ovf_q;
    assign Neg_Count       = neg_cnt_q;

endmodule

// File: tb/tb_alsu_result_flag_fifo.sv
// Bench for alsu_result_flag_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alsu_result_flag_fifo;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       Wr_Valid = 1'b0;
    logic       Wr_Ready;
    logic [3:0] Sel = 4'd0;
    logic [3:0] Result = 4'd0;
    logic       Negative_Sign_Flag = 1'b0;
    logic       Rd_Valid;
    logic       Rd_Ready = 1'b0;
    logic [3:0] Rd_Sel;
    logic [3:0] Rd_Result;
    logic       Rd_Negative;
    logic       Rd_Zero;
    logic [2:0] Count;
    logic       Overflow_Sticky;
    logic [7:0] Neg_Count;
    logic       Clear = 1'b0;

    alsu_result_flag_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_n(RST_n), .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Sel(Sel),
        .Result(Result), .Negative_Sign_Flag(Negative_Sign_Flag), .Rd_Valid(Rd_Valid),
        .Rd_Ready(Rd_Ready), .Rd_Sel(Rd_Sel), .Rd_Result(Rd_Result),
        .Rd_Negative(Rd_Negative), .Rd_Zero(Rd_Zero), .Count(Count),
        .Overflow_Sticky(Overflow_Sticky), .Neg_Count(Neg_Count), .Clear(Clear)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain queue of entries plus two status values.
    typedef struct {
        int sel;
        int res;
        int neg;
        int zero;
    } ent_t;

    ent_t m_q[$];
    int   m_ovf = 0;
    int   m_negcnt = 0;

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_q.delete();
            m_ovf = 0;
            m_negcnt = 0;
        end else begin
            ent_t e;
            int  sz;
            bit  wa, ra;
            sz = m_q.size();
            wa = Wr_Valid && (sz < DEPTH);
            ra = Rd_Ready && (sz > 0);
            e.sel  = int'(Sel);
            e.res  = int'(Result);
            e.neg  = (Negative_Sign_Flag && (Sel == 4'd0 || Sel == 4'd12)) ? 1 : 0;
            e.zero = (Result == 4'd0) ? 1 : 0;
            if (Wr_Valid && sz == DEPTH) m_ovf = 1;
            else if (Clear) m_ovf = 0;
            if (Clear) m_negcnt = (wa && e.neg == 1) ? 1 : 0;
            else if (wa && e.neg == 1 && m_negcnt < 255) m_negcnt++;
            if (ra) void'(m_q.pop_front());
            if (wa) m_q.push_back(e);
        end
    end

    // Compare process: every negedge, DUT outputs against the model.
    always @(negedge CLK) begin
        int sz;
        sz = m_q.size();
        check("wr_ready", int'(Wr_Ready), (sz < DEPTH) ? 1 : 0);
        check("rd_valid", int'(Rd_Valid), (sz > 0) ? 1 : 0);
        check("count", int'(Count), sz);
        check("overflow", int'(Overflow_Sticky), m_ovf);
        check("neg_count", int'(Neg_Count), m_negcnt);
        if (sz > 0) begin
            check("rd_sel", int'(Rd_Sel), m_q[0].sel);
            check("rd_result", int'(Rd_Result), m_q[0].res);
            check("rd_negative", int'(Rd_Negative), m_q[0].neg);
            check("rd_zero", int'(Rd_Zero), m_q[0].zero);
        end
    end

    // One clock: apply inputs, let the edge take them, return just after it.
    task automatic cyc(input bit wv, input int sel, input int res, input bit flag,
                       input bit rr, input bit clr);
        Wr_Valid = wv;
        Sel = 4'(sel);
        Result = 4'(res);
        Negative_Sign_Flag = flag;
        Rd_Ready = rr;
        Clear = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        #1;
        check("rst_count", int'(Count), 0);
        check("rst_rd_valid", int'(Rd_Valid), 0);
        check("rst_wr_ready", int'(Wr_Ready), 1);
        check("rst_overflow", int'(Overflow_Sticky), 0);
        check("rst_neg_count", int'(Neg_Count), 0);
        check("rst_rd_fields", int'({Rd_Sel, Rd_Result, Rd_Negative, Rd_Zero}), 0);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Fill then overflow.
        for (int i = 1; i <= 4; i++) cyc(1, 3, i, 0, 0, 0);
        check("fill_count", int'(Count), 4);
        check("fill_wr_ready", int'(Wr_Ready), 0);
        cyc(1, 3, 5, 0, 0, 0);
        check("ovf_set", int'(Overflow_Sticky), 1);
        check("ovf_count", int'(Count), 4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", int'(Rd_Result), i);
            cyc(0, 0, 0, 0, 1, 0);
        end
        check("drain_empty", int'(Rd_Valid), 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("ovf_clear", int'(Overflow_Sticky), 0);

        // Negative qualification and zero flag.
        cyc(1, 0, 3, 1, 0, 0);
        cyc(1, 12, 5, 1, 0, 0);
        cyc(1, 5, 7, 1, 0, 0);
        cyc(1, 3, 0, 0, 0, 0);
        check("negq_s0", int'(Rd_Negative), 1);
        cyc(0, 0, 0, 0, 1, 0);
        check("negq_s12", int'(Rd_Negative), 1);
        cyc(0, 0, 0, 0, 1, 0);
        check("negq_s5", int'(Rd_Negative), 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("zero_flag", int'(Rd_Zero), 1);
        cyc(0, 0, 0, 0, 1, 0);
        check("negq_count", int'(Neg_Count), 2);

        // Simultaneous push/pop at Count=2, then pop-only when full.
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 2, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            check("pp_head", int'(Rd_Result), (i + 1) % 16);
            cyc(1, 1, (i + 3) % 16, 0, 1, 0);
        end
        check("pp_count", int'(Count), 2);
        cyc(1, 1, 13, 0, 0, 0);
        cyc(1, 1, 14, 0, 0, 0);
        check("full_count", int'(Count), 4);
        cyc(1, 1, 15, 0, 1, 0);
        check("full_pop_only", int'(Count), 3);
        check("full_pp_ovf", int'(Overflow_Sticky), 1);

        // Asynchronous reset with 3 entries stored.
        do_reset();

        // Saturation of Neg_Count and Clear interactions.
        for (int i = 0; i < 300; i++) cyc(1, 0, i % 16, 1, 1, 0);
        check("sat_255", int'(Neg_Count), 255);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("clear_alone", int'(Neg_Count), 0);
        cyc(1, 12, 9, 1, 0, 1);
        check("clear_with_write", int'(Neg_Count), 1);
        for (int i = 0; i < 3; i++) cyc(1, 2, i, 0, 0, 0);
        cyc(1, 2, 7, 0, 0, 1);
        check("clear_vs_ovf", int'(Overflow_Sticky), 1);

        // Empty read, then single write visible after one edge.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
        check("empty_rd_count", int'(Count), 0);
        cyc(1, 6, 11, 0, 1, 0);
        check("post_empty_valid", int'(Rd_Valid), 1);
        check("post_empty_data", int'(Rd_Result), 11);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r, s;
            r = int'($urandom_range(0, 3));
            s = (r == 0) ? 0 : (r == 1) ? 12 : int'($urandom_range(0, 15));
            cyc(($urandom_range(0, 3) != 0), s, int'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1, ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 31) == 0));
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
